// File: rtl/cr_pkg.sv
// Shared types and constants for the call/return sequencer.
package cr_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2,
        FAULT  = 2'd3
    } cr_state_e;

    // Fault codes reported on Fault_Code
    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;
    localparam logic [1:0] FC_STK  = 2'b11;

    // Default geometry
    localparam int CR_ADDR_W = 13;
    localparam int CR_DEPTH  = 64;

endpackage

// File: rtl/call_return_ctrl.sv
// Call/return sequencer: issues push/pop strobes to the hardware return-address
// stack, tracks a shadow depth to pre-empt over/underflow, and converts the
// stack response into a registered one-cycle PC load for fetch.
module call_return_ctrl
    import cr_pkg::*;
#(
    parameter int ADDR_W = CR_ADDR_W,
    parameter int DEPTH  = CR_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              Sys_Clock,
    input  logic              Reset,
    input  logic              Instr_Valid,
    input  logic              Is_Call,
    input  logic              Is_Ret,
    input  logic [ADDR_W-1:0] Cur_PC,
    input  logic [ADDR_W-1:0] Target_Add,
    input  logic [ADDR_W-1:0] Ret_Add,
    input  logic              Err_Out,
    input  logic              Clear_Fault,
    output logic              Stack_Enable,
    output logic              Stack_Write,
    output logic [ADDR_W-1:0] NPPC,
    output logic              Stall,
    output logic              PC_Load,
    output logic [ADDR_W-1:0] PC_Next,
    output logic [PTR_W-1:0]  Depth,
    output logic              Fault,
    output logic [1:0]        Fault_Code
);

    localparam logic [PTR_W-1:0] DEPTH_FULL = PTR_W'(DEPTH);

    cr_state_e         state_q, state_d;
    logic              stack_en_q, stack_en_d;
    logic              stack_wr_q, stack_wr_d;
    logic [ADDR_W-1:0] nppc_q, nppc_d;
    logic              stall_q, stall_d;
    logic              pc_load_q, pc_load_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic [PTR_W-1:0]  depth_q, depth_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              push_q, push_d;

    // Next-state and next-output decode; outputs are registered from these
    always_comb begin
        state_d      = state_q;
        stack_en_d   = 1'b0;
        stack_wr_d   = 1'b0;
        nppc_d       = nppc_q;
        pc_load_d    = 1'b0;
        pc_next_d    = pc_next_q;
        depth_d      = depth_q;
        fault_code_d = fault_code_q;
        target_d     = target_q;
        push_d       = push_q;

        case (state_q)
            IDLE: begin
                if (Instr_Valid && Is_Call) begin
                    // CALL has priority over a simultaneous RET
                    if (depth_q == DEPTH_FULL) begin
                        state_d      = FAULT;
                        fault_code_d = FC_OVF;
                    end else begin
                        stack_en_d = 1'b1;
                        stack_wr_d = 1'b1;
                        nppc_d     = Cur_PC + ADDR_W'(1);
                        target_d   = Target_Add;
                        push_d     = 1'b1;
                        state_d    = WAIT;
                    end
                end else if (Instr_Valid && Is_Ret) begin
                    if (depth_q == PTR_W'(0)) begin
                        state_d      = FAULT;
                        fault_code_d = FC_UNF;
                    end else begin
                        stack_en_d = 1'b1;
                        stack_wr_d = 1'b0;
                        push_d     = 1'b0;
                        state_d    = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Stack response settled on the falling edge; sample it now
                if (Err_Out) begin
                    state_d      = FAULT;
                    fault_code_d = FC_STK;
                end else begin
                    state_d   = COMMIT;
                    pc_load_d = 1'b1;
                    if (push_q) begin
                        pc_next_d = target_q;
                        depth_d   = depth_q + PTR_W'(1);
                    end else begin
                        pc_next_d = Ret_Add;
                        depth_d   = depth_q - PTR_W'(1);
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (Clear_Fault) begin
                    state_d      = IDLE;
                    fault_code_d = FC_NONE;
                end else begin
                    state_d = FAULT;
                end
            end
            default: begin
                state_d      = IDLE;
                fault_code_d = FC_NONE;
            end
        endcase

        stall_d = (state_d != IDLE);
        fault_d = (state_d == FAULT);
    end

    // State and output registers; async reset clears everything
    always_ff @(posedge Sys_Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            stack_en_q   <= 1'b0;
            stack_wr_q   <= 1'b0;
            nppc_q       <= '0;
            stall_q      <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_next_q    <= '0;
            depth_q      <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            target_q     <= '0;
            push_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stack_en_q   <= stack_en_d;
            stack_wr_q   <= stack_wr_d;
            nppc_q       <= nppc_d;
            stall_q      <= stall_d;
            pc_load_q    <= pc_load_d;
            pc_next_q    <= pc_next_d;
            depth_q      <= depth_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            target_q     <= target_d;
            push_q       <= push_d;
        end
    end

    assign Stack_Enable = stack_en_q;
    assign Stack_Write  = stack_wr_q;
    assign NPPC         = nppc_q;
    assign Stall        = stall_q;
    assign PC_Load      = pc_load_q;
    assign PC_Next      = pc_next_q;
    assign Depth        = depth_q;
    assign Fault        = fault_q;
    assign Fault_Code   = fault_code_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Scoreboard bench for call_return_ctrl with a behavioural return-address stack.
module tb_call_return_ctrl;

    logic        Sys_Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Instr_Valid = 1'b0;
    logic        Is_Call = 1'b0;
    logic        Is_Ret = 1'b0;
    logic [12:0] Cur_PC = 13'h0;
    logic [12:0] Target_Add = 13'h0;
    logic [12:0] Ret_Add = 13'h0;
    logic        Err_Out;
    logic        Clear_Fault = 1'b0;
    logic        Stack_Enable, Stack_Write, Stall, PC_Load, Fault;
    logic [12:0] NPPC, PC_Next;
    logic [6:0]  Depth;
    logic [1:0]  Fault_Code;

    logic        force_err = 1'b0;
    assign Err_Out = force_err;

    int checks = 0;
    int errors = 0;

    logic [12:0] stk[$];       // behavioural stack contents
    logic [13:0] exp_stk[$];   // {write, nppc}
    logic [19:0] exp_pc[$];    // {pc_next, depth}
    logic [8:0]  exp_flt[$];   // {code, depth}
    logic        fault_prev = 1'b0;

    call_return_ctrl dut (
        .Sys_Clock(Sys_Clock), .Reset(Reset), .Instr_Valid(Instr_Valid),
        .Is_Call(Is_Call), .Is_Ret(Is_Ret), .Cur_PC(Cur_PC),
        .Target_Add(Target_Add), .Ret_Add(Ret_Add), .Err_Out(Err_Out),
        .Clear_Fault(Clear_Fault), .Stack_Enable(Stack_Enable),
        .Stack_Write(Stack_Write), .NPPC(NPPC), .Stall(Stall),
        .PC_Load(PC_Load), .PC_Next(PC_Next), .Depth(Depth),
        .Fault(Fault), .Fault_Code(Fault_Code)
    );

    always #5 Sys_Clock = ~Sys_Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor + stack model: sample on the falling edge, between rising edges
    always @(negedge Sys_Clock) begin
        if (Reset) begin
            if (Stack_Enable) begin
                if (!Err_Out) begin
                    if (Stack_Write) stk.push_back(NPPC);
                    else if (stk.size() > 0) Ret_Add = stk.pop_back();
                end
                if (exp_stk.size() == 0) begin
                    chk("spurious_strobe", 64'd1, 64'd0);
                end else begin
                    logic [13:0] e;
                    e = exp_stk.pop_front();
                    chk("stack_write", {63'd0, Stack_Write}, {63'd0, e[13]});
                    if (e[13]) chk("nppc", {51'd0, NPPC}, {51'd0, e[12:0]});
                end
            end
            if (PC_Load) begin
                if (exp_pc.size() == 0) begin
                    chk("spurious_pc_load", 64'd1, 64'd0);
                end else begin
                    logic [19:0] p;
                    p = exp_pc.pop_front();
                    chk("pc_next", {51'd0, PC_Next}, {51'd0, p[19:7]});
                    chk("depth_commit", {57'd0, Depth}, {57'd0, p[6:0]});
                end
            end
            if (Fault && !fault_prev) begin
                if (exp_flt.size() == 0) begin
                    chk("spurious_fault", 64'd1, 64'd0);
                end else begin
                    logic [8:0] f;
                    f = exp_flt.pop_front();
                    chk("fault_code", {62'd0, Fault_Code}, {62'd0, f[8:7]});
                    chk("depth_fault", {57'd0, Depth}, {57'd0, f[6:0]});
                    chk("stall_fault", {63'd0, Stall}, 64'd1);
                end
            end
        end
        fault_prev = Fault;
    end

    // Wait (bounded) until the DUT is idle; returns on a falling edge
    task automatic wait_idle();
        for (int n = 0; n < 20; n++) begin
            @(negedge Sys_Clock);
            if (!Stall) return;
        end
        chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // Present one instruction for exactly one rising edge
    task automatic drive(input logic c, input logic r, input logic [12:0] cur, input logic [12:0] tgt);
        Instr_Valid = 1'b1; Is_Call = c; Is_Ret = r; Cur_PC = cur; Target_Add = tgt;
        @(negedge Sys_Clock);
        Instr_Valid = 1'b0; Is_Call = 1'b0; Is_Ret = 1'b0;
    endtask

    task automatic clear_fault(input logic [6:0] exp_depth);
        repeat (2) @(negedge Sys_Clock);
        Clear_Fault = 1'b1;
        @(negedge Sys_Clock);
        Clear_Fault = 1'b0;
        chk("fault_cleared", {62'd0, Fault, Stall}, 64'd0);
        chk("code_cleared", {62'd0, Fault_Code}, 64'd0);
        chk("depth_kept", {57'd0, Depth}, {57'd0, exp_depth});
    endtask

    function automatic logic [63:0] all_outs();
        return {24'd0, Stack_Enable, Stack_Write, NPPC, Stall, PC_Load, PC_Next, Depth, Fault, Fault_Code};
    endfunction

    initial begin
        repeat (3) @(negedge Sys_Clock);
        chk("reset_outputs", all_outs(), 64'd0);
        Reset = 1'b1;

        // CALL 0x0010 -> 0x0200
        wait_idle();
        exp_stk.push_back({1'b1, 13'h0011});
        exp_pc.push_back({13'h0200, 7'd1});
        drive(1'b1, 1'b0, 13'h0010, 13'h0200);
        // RET returns 0x0011
        wait_idle();
        exp_stk.push_back({1'b0, 13'h0000});
        exp_pc.push_back({13'h0011, 7'd0});
        drive(1'b0, 1'b1, 13'h0040, 13'h0000);
        // RET at depth 0 -> underflow, no strobe
        wait_idle();
        exp_flt.push_back({2'b10, 7'd0});
        drive(1'b0, 1'b1, 13'h0050, 13'h0000);
        clear_fault(7'd0);

        // Valid with no flags: nothing happens
        wait_idle();
        drive(1'b0, 1'b0, 13'h0060, 13'h0061);
        @(negedge Sys_Clock);
        chk("noop_stall", {63'd0, Stall}, 64'd0);

        // Fill the stack
        for (int i = 0; i < 64; i++) begin
            wait_idle();
            exp_stk.push_back({1'b1, 13'h0101 + 13'(i)});
            exp_pc.push_back({13'h0400 + 13'(i), 7'(i + 1)});
            drive(1'b1, 1'b0, 13'h0100 + 13'(i), 13'h0400 + 13'(i));
        end
        // 65th CALL -> overflow, no strobe
        wait_idle();
        exp_flt.push_back({2'b01, 7'd64});
        drive(1'b1, 1'b0, 13'h0700, 13'h0800);
        // Instructions are ignored while faulted
        drive(1'b1, 1'b0, 13'h0710, 13'h0810);
        clear_fault(7'd64);

        // Pop top entry (0x0140), then CALL at 0x1FFF with RET also set
        wait_idle();
        exp_stk.push_back({1'b0, 13'h0000});
        exp_pc.push_back({13'h0140, 7'd63});
        drive(1'b0, 1'b1, 13'h0900, 13'h0000);
        wait_idle();
        exp_stk.push_back({1'b1, 13'h0000});
        exp_pc.push_back({13'h0ABC, 7'd64});
        drive(1'b1, 1'b1, 13'h1FFF, 13'h0ABC);
        wait_idle();
        exp_stk.push_back({1'b0, 13'h0000});
        exp_pc.push_back({13'h0000, 7'd63});
        drive(1'b0, 1'b1, 13'h0AC0, 13'h0000);

        // Stack error during push
        wait_idle();
        force_err = 1'b1;
        exp_stk.push_back({1'b1, 13'h0021});
        exp_flt.push_back({2'b11, 7'd63});
        drive(1'b1, 1'b0, 13'h0020, 13'h0300);
        repeat (2) @(negedge Sys_Clock);
        force_err = 1'b0;
        clear_fault(7'd63);

        // Reset asserted while in WAIT
        wait_idle();
        exp_stk.push_back({1'b1, 13'h0031});
        drive(1'b1, 1'b0, 13'h0030, 13'h0310);
        #2 Reset = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 64'd0);
        stk.delete();
        repeat (2) @(negedge Sys_Clock);
        Reset = 1'b1;
        wait_idle();
        exp_stk.push_back({1'b1, 13'h0011});
        exp_pc.push_back({13'h0200, 7'd1});
        drive(1'b1, 1'b0, 13'h0010, 13'h0200);

        repeat (6) @(negedge Sys_Clock);
        chk("final_depth", {57'd0, Depth}, 64'd1);
        chk("exp_stk_drained", 64'(exp_stk.size()), 64'd0);
        chk("exp_pc_drained", 64'(exp_pc.size()), 64'd0);
        chk("exp_flt_drained", 64'(exp_flt.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
